// File: rtl/i2c_regfile_bank.sv
// I2C register-file bank: byte-addressed R/W registers with atomic 16-bit
// commits, optional self-clearing pulse registers, and read-only status words.
module i2c_rw_slot #(
  parameter logic [15:0] RST_VAL   = 16'h0000,
  parameter logic        PULSE     = 1'b0,
  parameter int          PULSE_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [15:0] wdata,
  output logic [15:0] q,
  output logic        strobe
);
  logic [15:0] q_d, q_q;
  logic [3:0]  cnt_d, cnt_q;
  logic        strobe_d, strobe_q;

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    strobe_d = commit;
    if (commit) begin
      q_d = wdata;
      if (PULSE) cnt_d = 4'(PULSE_LEN);
    end else if (cnt_q != 4'd0) begin
      // counter only ever loads for pulse registers, so plain regs never clear
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q      <= RST_VAL;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign q      = q_q;
  assign strobe = strobe_q;
endmodule

module i2c_regfile_bank #(
  parameter int                    NUM_RW     = 8,
  parameter int                    NUM_RO     = 4,
  parameter logic [7:0]            RO_BASE    = 8'h40,
  parameter logic [16*NUM_RW-1:0]  RESET_VALS = {NUM_RW{16'h0000}},
  parameter logic [NUM_RW-1:0]     PULSE_MASK = {NUM_RW{1'b0}},
  parameter int                    PULSE_LEN  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   data_vld,
  input  logic                   r_w,
  input  logic [7:0]             i2c_to_data,
  output logic [7:0]             data_to_i2c,
  input  logic [16*NUM_RO-1:0]   ro_regs,
  output logic [16*NUM_RW-1:0]   rw_regs,
  output logic [NUM_RW-1:0]      wr_strobe,
  output logic [7:0]             err_cnt
);
  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  localparam logic [8:0] RW_END = 9'(2*NUM_RW);
  localparam logic [8:0] RO_LO  = {1'b0, RO_BASE};
  localparam logic [8:0] RO_HI  = 9'({1'b0, RO_BASE} + 9'(2*NUM_RO));

  state_t      state_d, state_q;
  logic [7:0]  ptr_d, ptr_q;
  logic [7:0]  stage_d, stage_q;
  logic        stage_vld_d, stage_vld_q;
  logic [6:0]  stage_idx_d, stage_idx_q;
  logic [7:0]  shadow_d, shadow_q;
  logic        shadow_vld_d, shadow_vld_q;
  logic [6:0]  shadow_idx_d, shadow_idx_q;
  logic [7:0]  err_cnt_d, err_cnt_q;
  logic [7:0]  data_d, data_q;

  logic [NUM_RW-1:0][15:0] rw_q;
  logic [NUM_RW-1:0][15:0] wdata;
  logic [NUM_RW-1:0]       commit;
  logic [NUM_RO-1:0][15:0] ro_w;
  logic                    rw_hit, ro_hit, hit, wr_odd, err_inc;
  logic [6:0]              ro_idx;
  logic [15:0]             live;
  logic [7:0]              rd_byte;

  assign ro_w   = ro_regs;
  assign rw_hit = {1'b0, ptr_q} < RW_END;
  assign ro_hit = ({1'b0, ptr_q} >= RO_LO) && ({1'b0, ptr_q} < RO_HI);
  assign hit    = rw_hit | ro_hit;
  assign ro_idx = ptr_q[7:1] - RO_BASE[7:1];

  always_comb begin
    live = '0;
    for (int k = 0; k < NUM_RW; k++)
      if (rw_hit && ptr_q[7:1] == 7'(k)) live = rw_q[k];
    for (int k = 0; k < NUM_RO; k++)
      if (ro_hit && ro_idx == 7'(k)) live = ro_w[k];
    if (!hit)                                                rd_byte = 8'h00;
    else if (!ptr_q[0])                                      rd_byte = live[7:0];
    else if (shadow_vld_q && shadow_idx_q == ptr_q[7:1])     rd_byte = shadow_q;
    else                                                     rd_byte = live[15:8];
  end

  // odd-byte commit: merge with the staged low byte only if it belongs to this register
  always_comb begin
    for (int k = 0; k < NUM_RW; k++) begin
      wdata[k]  = {i2c_to_data,
                   (stage_vld_q && stage_idx_q == 7'(k)) ? stage_q : rw_q[k][7:0]};
      commit[k] = wr_odd && (ptr_q[7:1] == 7'(k));
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    stage_d      = stage_q;
    stage_vld_d  = stage_vld_q;
    stage_idx_d  = stage_idx_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    shadow_idx_d = shadow_idx_q;
    wr_odd       = 1'b0;
    err_inc      = 1'b0;
    data_d       = r_w ? rd_byte : 8'h00;
    if (start || stop) begin
      state_d      = start ? CMD : IDLE;
      stage_vld_d  = 1'b0;
      shadow_vld_d = 1'b0;
    end else begin
      // high byte is captured alongside the low byte presented to the master
      if (r_w && (state_q == CMD || state_q == RD) && hit && !ptr_q[0]) begin
        shadow_d     = live[15:8];
        shadow_vld_d = 1'b1;
        shadow_idx_d = ptr_q[7:1];
      end
      if (data_vld) begin
        unique case (state_q)
          CMD: begin
            if (!r_w) begin
              ptr_d   = i2c_to_data;
              state_d = WR;
            end else begin
              err_inc = !hit;
              ptr_d   = ptr_q + 8'd1;
              state_d = RD;
            end
          end
          WR: begin
            if (rw_hit && !ptr_q[0]) begin
              stage_d     = i2c_to_data;
              stage_vld_d = 1'b1;
              stage_idx_d = ptr_q[7:1];
            end else if (rw_hit) begin
              wr_odd      = 1'b1;
              stage_vld_d = 1'b0;
            end else begin
              err_inc = 1'b1;
            end
            ptr_d = ptr_q + 8'd1;
          end
          RD: begin
            err_inc = !hit;
            ptr_d   = ptr_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      stage_q      <= '0;
      stage_vld_q  <= 1'b0;
      stage_idx_q  <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      shadow_idx_q <= '0;
      err_cnt_q    <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      stage_q      <= stage_d;
      stage_vld_q  <= stage_vld_d;
      stage_idx_q  <= stage_idx_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      shadow_idx_q <= shadow_idx_d;
      err_cnt_q    <= err_cnt_d;
      data_q       <= data_d;
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_slot
    i2c_rw_slot #(
      .RST_VAL   (RESET_VALS[16*k +: 16]),
      .PULSE     (PULSE_MASK[k]),
      .PULSE_LEN (PULSE_LEN)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .commit (commit[k]),
      .wdata  (wdata[k]),
      .q      (rw_q[k]),
      .strobe (wr_strobe[k])
    );
  end

  assign rw_regs     = rw_q;
  assign data_to_i2c = data_q;
  assign err_cnt     = err_cnt_q;
endmodule
